// File: rtl/axi_master.sv
// -----------------------------------------------------------------------------
// axi_master
//
// Single-outstanding AXI master front end. A user command (read or write)
// is accepted in IDLE and turned into one AXI burst; write data streams from
// the user wd_* port straight onto the W channel, read data streams from the
// R channel straight onto the user rd_* port. Each transaction finishes with
// one completion report on done_*.
//
// Parameters
//   AXI_SIZE   beat size driven on aw_size/ar_size (3'b010 = 4 bytes)
//   RESP_HOLD  1: done_valid held until done_ready; 0: single-cycle pulse
//
// Configuration macro
//   AXI_MASTER_INCR_BURST_EN  defined  : INCR bursts, aw_len/ar_len = cmd_len
//                             undefined: FIXED single-beat transfers,
//                                        cmd_len ignored, w_last always 1
//
// Ports
//   a_clk, a_resetn              clock, synchronous active-low reset
//   cmd_*                        command handshake: write/id/addr/len
//   wd_*                         user write-data stream (into the master)
//   rd_*                         user read-data stream (out of the master)
//   done_*                       completion report: write/id/resp
//   aw_*, w_*, b_*, ar_*, r_*    AXI master channels
// -----------------------------------------------------------------------------
module axi_master #(
    parameter logic [2:0] AXI_SIZE  = 3'b010,
    parameter int         RESP_HOLD = 0
) (
    input  logic        a_clk,
    input  logic        a_resetn,
    // command
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [3:0]  cmd_id,
    input  logic [31:0] cmd_addr,
    input  logic [3:0]  cmd_len,
    // user write data
    input  logic [31:0] wd_data,
    input  logic [3:0]  wd_strb,
    input  logic        wd_valid,
    output logic        wd_ready,
    // user read data
    output logic [31:0] rd_data,
    output logic        rd_last,
    output logic        rd_valid,
    input  logic        rd_ready,
    // completion
    output logic        done_valid,
    input  logic        done_ready,
    output logic        done_write,
    output logic [3:0]  done_id,
    output logic [1:0]  done_resp,
    // AXI write address
    output logic [3:0]  aw_id,
    output logic [31:0] aw_addr,
    output logic [3:0]  aw_len,
    output logic [2:0]  aw_size,
    output logic [1:0]  aw_burst,
    output logic        aw_valid,
    input  logic        aw_ready,
    // AXI write data
    output logic [3:0]  w_id,
    output logic [31:0] w_data,
    output logic [3:0]  w_strb,
    output logic        w_last,
    output logic        w_valid,
    input  logic        w_ready,
    // AXI write response
    input  logic [3:0]  b_id,
    input  logic [1:0]  b_resp,
    input  logic        b_valid,
    output logic        b_ready,
    // AXI read address
    output logic [3:0]  ar_id,
    output logic [31:0] ar_addr,
    output logic [3:0]  ar_len,
    output logic [2:0]  ar_size,
    output logic [1:0]  ar_burst,
    output logic        ar_valid,
    input  logic        ar_ready,
    // AXI read data
    input  logic [3:0]  r_id,
    input  logic [31:0] r_data,
    input  logic [1:0]  r_resp,
    input  logic        r_last,
    input  logic        r_valid,
    output logic        r_ready
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_WRESP,
        S_RADDR,
        S_RDATA,
        S_DONE
    } state_t;

    localparam logic [1:0] RESP_SLVERR = 2'b10;

    state_t      state_q, state_d;
    logic [3:0]  id_q;
    logic [31:0] addr_q;
    logic [3:0]  len_q;
    logic        write_q;
    logic [3:0]  beat_q;
    logic        aw_done_q;
    logic        w_done_q;
    logic [1:0]  resp_q;

    logic [3:0]  len_in;
    logic [1:0]  burst;
    logic        aw_hs;
    logic        w_hs;
    logic        r_hs;

`ifdef AXI_MASTER_INCR_BURST_EN
    assign burst  = 2'b01;
    assign len_in = cmd_len;
`else
    // Single-beat mode: the requested length is deliberately discarded.
    logic unused_cmd_len;
    assign burst          = 2'b00;
    assign len_in         = 4'd0;
    assign unused_cmd_len = ^cmd_len;
`endif

    // The write response ID carries no information with one transaction
    // outstanding, so it is not checked.
    logic unused_b_id;
    assign unused_b_id = ^b_id;

    assign aw_hs = aw_valid && aw_ready;
    assign w_hs  = w_valid && w_ready;
    assign r_hs  = r_valid && r_ready;

    // Address/ID/len come only from registers, so they stay stable while a
    // valid is waiting for its ready.
    assign aw_id    = id_q;
    assign aw_addr  = addr_q;
    assign aw_len   = len_q;
    assign aw_size  = AXI_SIZE;
    assign aw_burst = burst;
    assign ar_id    = id_q;
    assign ar_addr  = addr_q;
    assign ar_len   = len_q;
    assign ar_size  = AXI_SIZE;
    assign ar_burst = burst;

    assign w_id    = id_q;
    assign w_data  = wd_data;
    assign w_strb  = wd_strb;
    assign w_last  = (beat_q == len_q);

    assign rd_data = r_data;
    assign rd_last = r_last;

    assign done_write = write_q;
    assign done_id    = id_q;
    assign done_resp  = resp_q;

    // Next-state and handshake outputs.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case statement can leave a latch behind.
        state_d    = state_q;
        cmd_ready  = 1'b0;
        aw_valid   = 1'b0;
        w_valid    = 1'b0;
        wd_ready   = 1'b0;
        b_ready    = 1'b0;
        ar_valid   = 1'b0;
        rd_valid   = 1'b0;
        r_ready    = 1'b0;
        done_valid = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    state_d = cmd_write ? S_WRITE : S_RADDR;
                end
            end
            S_WRITE: begin
                // AW and W run independently; each side stops once done.
                aw_valid = !aw_done_q;
                w_valid  = wd_valid && !w_done_q;
                wd_ready = w_ready && !w_done_q;
                if ((aw_done_q || aw_ready) &&
                    (w_done_q || (wd_valid && w_ready && w_last))) begin
                    state_d = S_WRESP;
                end
            end
            S_WRESP: begin
                b_ready = 1'b1;
                if (b_valid) begin
                    state_d = S_DONE;
                end
            end
            S_RADDR: begin
                ar_valid = 1'b1;
                if (ar_ready) begin
                    state_d = S_RDATA;
                end
            end
            S_RDATA: begin
                rd_valid = r_valid;
                r_ready  = rd_ready;
                if (r_valid && rd_ready && r_last) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done_valid = 1'b1;
                if (RESP_HOLD == 0 || done_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge a_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!a_resetn) begin
            state_q   <= S_IDLE;
            id_q      <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            write_q   <= 1'b0;
            beat_q    <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            resp_q    <= '0;
        end else begin
            state_q <= state_d;
            unique case (state_q)
                S_IDLE: begin
                    if (cmd_valid) begin
                        id_q      <= cmd_id;
                        addr_q    <= cmd_addr;
                        len_q     <= len_in;
                        write_q   <= cmd_write;
                        beat_q    <= '0;
                        aw_done_q <= 1'b0;
                        w_done_q  <= 1'b0;
                        resp_q    <= '0;
                    end
                end
                S_WRITE: begin
                    if (aw_hs) begin
                        aw_done_q <= 1'b1;
                    end
                    if (w_hs) begin
                        beat_q <= beat_q + 4'd1;
                        if (w_last) begin
                            w_done_q <= 1'b1;
                        end
                    end
                end
                S_WRESP: begin
                    if (b_valid) begin
                        resp_q <= b_resp;
                    end
                end
                S_RDATA: begin
                    // An ID mismatch forces SLVERR for the rest of the burst;
                    // otherwise the first non-OKAY response is kept.
                    if (r_hs) begin
                        if (r_id != id_q) begin
                            resp_q <= RESP_SLVERR;
                        end else if (resp_q == 2'b00) begin
                            resp_q <= r_resp;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_master.sv
// -----------------------------------------------------------------------------
// tb_axi_master
//
// Randomized self-checking bench for axi_master. The bench plays both the
// user and the AXI slave; expected AXI fields, beat counts, w_last positions
// and completion responses are computed from the command and from the
// responses the bench itself returns. A second instance with RESP_HOLD=1 is
// used for the held-completion scenario.
// -----------------------------------------------------------------------------
module tb_axi_master;

`ifdef AXI_MASTER_INCR_BURST_EN
    localparam bit INCR = 1'b1;
`else
    localparam bit INCR = 1'b0;
`endif

    logic        a_clk;
    logic        a_resetn;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [3:0]  cmd_id, cmd_len;
    logic [31:0] cmd_addr;
    logic [31:0] wd_data;
    logic [3:0]  wd_strb;
    logic        wd_valid, wd_ready;
    logic [31:0] rd_data;
    logic        rd_last, rd_valid, rd_ready;
    logic        done_valid, done_ready, done_write;
    logic [3:0]  done_id;
    logic [1:0]  done_resp;
    logic [3:0]  aw_id, aw_len;
    logic [31:0] aw_addr;
    logic [2:0]  aw_size;
    logic [1:0]  aw_burst;
    logic        aw_valid, aw_ready;
    logic [3:0]  w_id;
    logic [31:0] w_data;
    logic [3:0]  w_strb;
    logic        w_last, w_valid, w_ready;
    logic [3:0]  b_id;
    logic [1:0]  b_resp;
    logic        b_valid, b_ready;
    logic [3:0]  ar_id, ar_len;
    logic [31:0] ar_addr;
    logic [2:0]  ar_size;
    logic [1:0]  ar_burst;
    logic        ar_valid, ar_ready;
    logic [3:0]  r_id;
    logic [31:0] r_data;
    logic [1:0]  r_resp;
    logic        r_last, r_valid, r_ready;

    // RESP_HOLD=1 instance: fixed write command, always-ready slave.
    logic        h_cmd_valid, h_done_ready;
    logic        h_cmd_ready, h_wd_ready, h_rd_last, h_rd_valid;
    logic [31:0] h_rd_data, h_aw_addr, h_w_data, h_ar_addr;
    logic        h_done_valid, h_done_write;
    logic [3:0]  h_done_id, h_aw_id, h_aw_len, h_w_id, h_w_strb, h_ar_id, h_ar_len;
    logic [1:0]  h_done_resp, h_aw_burst, h_ar_burst;
    logic [2:0]  h_aw_size, h_ar_size;
    logic        h_aw_valid, h_w_last, h_w_valid, h_b_ready, h_ar_valid, h_r_ready;

    int n_cmp = 0;
    int n_err = 0;

    axi_master u_dut (
        .a_clk(a_clk), .a_resetn(a_resetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_id(cmd_id), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wd_data(wd_data), .wd_strb(wd_strb), .wd_valid(wd_valid), .wd_ready(wd_ready),
        .rd_data(rd_data), .rd_last(rd_last), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .done_valid(done_valid), .done_ready(done_ready), .done_write(done_write),
        .done_id(done_id), .done_resp(done_resp),
        .aw_id(aw_id), .aw_addr(aw_addr), .aw_len(aw_len), .aw_size(aw_size),
        .aw_burst(aw_burst), .aw_valid(aw_valid), .aw_ready(aw_ready),
        .w_id(w_id), .w_data(w_data), .w_strb(w_strb), .w_last(w_last),
        .w_valid(w_valid), .w_ready(w_ready),
        .b_id(b_id), .b_resp(b_resp), .b_valid(b_valid), .b_ready(b_ready),
        .ar_id(ar_id), .ar_addr(ar_addr), .ar_len(ar_len), .ar_size(ar_size),
        .ar_burst(ar_burst), .ar_valid(ar_valid), .ar_ready(ar_ready),
        .r_id(r_id), .r_data(r_data), .r_resp(r_resp), .r_last(r_last),
        .r_valid(r_valid), .r_ready(r_ready)
    );

    axi_master #(.RESP_HOLD(1)) u_hold (
        .a_clk(a_clk), .a_resetn(a_resetn),
        .cmd_valid(h_cmd_valid), .cmd_ready(h_cmd_ready), .cmd_write(1'b1),
        .cmd_id(4'h9), .cmd_addr(32'h0000_0040), .cmd_len(4'd0),
        .wd_data(32'hCAFE_F00D), .wd_strb(4'hF), .wd_valid(1'b1), .wd_ready(h_wd_ready),
        .rd_data(h_rd_data), .rd_last(h_rd_last), .rd_valid(h_rd_valid), .rd_ready(1'b0),
        .done_valid(h_done_valid), .done_ready(h_done_ready), .done_write(h_done_write),
        .done_id(h_done_id), .done_resp(h_done_resp),
        .aw_id(h_aw_id), .aw_addr(h_aw_addr), .aw_len(h_aw_len), .aw_size(h_aw_size),
        .aw_burst(h_aw_burst), .aw_valid(h_aw_valid), .aw_ready(1'b1),
        .w_id(h_w_id), .w_data(h_w_data), .w_strb(h_w_strb), .w_last(h_w_last),
        .w_valid(h_w_valid), .w_ready(1'b1),
        .b_id(4'h9), .b_resp(2'b01), .b_valid(1'b1), .b_ready(h_b_ready),
        .ar_id(h_ar_id), .ar_addr(h_ar_addr), .ar_len(h_ar_len), .ar_size(h_ar_size),
        .ar_burst(h_ar_burst), .ar_valid(h_ar_valid), .ar_ready(1'b0),
        .r_id(4'h0), .r_data(32'h0), .r_resp(2'b00), .r_last(1'b0),
        .r_valid(1'b0), .r_ready(h_r_ready)
    );

    initial a_clk = 1'b0;
    always #5 a_clk = ~a_clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h at t=%0t", tag, act, exp, $time);
        end
    endtask

    // Beats-1 the AXI burst must carry for a requested length.
    function automatic int eff_len(input logic [3:0] len);
        return INCR ? int'(len) : 0;
    endfunction

    function automatic logic [1:0] exp_burst();
        return INCR ? 2'b01 : 2'b00;
    endfunction

    task automatic idle_inputs();
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_id = '0; cmd_addr = '0; cmd_len = '0;
        wd_data = '0; wd_strb = '0; wd_valid = 1'b0;
        rd_ready = 1'b0; done_ready = 1'b0;
        aw_ready = 1'b0; w_ready = 1'b0;
        b_id = '0; b_resp = '0; b_valid = 1'b0;
        ar_ready = 1'b0;
        r_id = '0; r_data = '0; r_resp = '0; r_last = 1'b0; r_valid = 1'b0;
    endtask

    // Issue a command; returns at +1 after the accepting edge.
    task automatic send_cmd(input logic wr, input logic [3:0] id,
                            input logic [31:0] addr, input logic [3:0] len);
        @(posedge a_clk); #1;
        cmd_valid = 1'b1; cmd_write = wr; cmd_id = id; cmd_addr = addr; cmd_len = len;
        #1;
        check("cmd_ready_idle", cmd_ready, 1);
        @(posedge a_clk); #1;
        // Scramble the command bus: AXI fields must come from registers.
        cmd_valid = 1'b0; cmd_id = 4'($urandom); cmd_addr = $urandom; cmd_len = 4'($urandom);
    endtask

    task automatic run_write(input logic [3:0] id, input logic [31:0] addr,
                             input logic [3:0] len, input int aw_delay,
                             input int pct, input logic [1:0] bresp);
        int el, beats, cyc, aw_cyc, wl_cyc, dly;
        bit aw_done, exp_aw;
        el = eff_len(len); beats = 0; cyc = 0; aw_cyc = -1; wl_cyc = -2; aw_done = 0;
        send_cmd(1'b1, id, addr, len);
        while (!(aw_done && beats > el) && cyc < 200) begin
            aw_ready = (aw_delay >= 0) ? (cyc >= aw_delay) : ($urandom_range(99) < pct);
            w_ready  = (pct == 100) || ($urandom_range(99) < pct);
            wd_valid = (pct == 100) || ($urandom_range(1) == 1);
            wd_data  = $urandom;
            wd_strb  = 4'($urandom);
            exp_aw   = !aw_done;
            #1;
            if (cyc == 0) check("wr_aw_latency", aw_valid, 1);
            check("wr_aw_valid", aw_valid, exp_aw);
            if (exp_aw) begin
                check("wr_aw_id", aw_id, id);
                check("wr_aw_addr", aw_addr, addr);
                check("wr_aw_len", aw_len, el);
                check("wr_aw_size", aw_size, 3'b010);
                check("wr_aw_burst", aw_burst, exp_burst());
            end
            check("wr_w_valid", w_valid, wd_valid && (beats <= el));
            check("wr_wd_ready", wd_ready, w_ready && (beats <= el));
            check("wr_no_done", done_valid, 0);
            if (wd_valid && w_ready && beats <= el) begin
                check("wr_w_data", w_data, wd_data);
                check("wr_w_strb", w_strb, wd_strb);
                check("wr_w_id", w_id, id);
                check("wr_w_last", w_last, beats == el);
                if (beats == el) wl_cyc = cyc;
                beats++;
            end
            if (exp_aw && aw_ready) begin
                aw_done = 1;
                aw_cyc = cyc;
            end
            @(posedge a_clk); #1;
            cyc++;
        end
        check("wr_data_phase_in_budget", cyc < 200, 1);
        if (pct == 100 && aw_delay == 0 && el == 0) check("wr_aw_w_same_cycle", aw_cyc, wl_cyc);
        aw_ready = 1'b0; w_ready = 1'b0; wd_valid = 1'b0;

        dly = (pct == 100) ? 0 : int'($urandom_range(3));
        for (int i = 0; i < dly; i++) begin
            #1;
            check("wr_b_ready_wait", b_ready, 1);
            check("wr_no_done_wait", done_valid, 0);
            @(posedge a_clk); #1;
        end
        b_valid = 1'b1; b_resp = bresp; b_id = id;
        #1;
        check("wr_b_ready", b_ready, 1);
        @(posedge a_clk); #1;
        b_valid = 1'b0; b_resp = 2'($urandom);
        #1;
        check("wr_done_valid", done_valid, 1);
        check("wr_done_write", done_write, 1);
        check("wr_done_id", done_id, id);
        check("wr_done_resp", done_resp, bresp);
        check("wr_done_cmd_ready", cmd_ready, 0);
        check("wr_done_w_valid", w_valid, 0);
        @(posedge a_clk); #1; #1;
        check("wr_done_pulse", done_valid, 0);
        check("wr_back_idle", cmd_ready, 1);
    endtask

    task automatic run_read(input logic [3:0] id, input logic [31:0] addr,
                            input logic [3:0] len, input int pct, input bit toggle,
                            input int err_beat, input logic [1:0] err_val,
                            input int bad_beat, input logic [3:0] bad_id);
        int el, beats, cyc;
        bit ar_done, mism;
        logic [1:0] first;
        el = eff_len(len); beats = 0; cyc = 0; ar_done = 0; mism = 0; first = 2'b00;
        send_cmd(1'b0, id, addr, len);
        while (!ar_done && cyc < 100) begin
            ar_ready = (pct == 100) || ($urandom_range(99) < pct);
            r_valid  = ($urandom_range(1) == 1);
            rd_ready = 1'b1;
            #1;
            if (cyc == 0) check("rd_ar_latency", ar_valid, 1);
            check("rd_ar_valid", ar_valid, 1);
            check("rd_ar_id", ar_id, id);
            check("rd_ar_addr", ar_addr, addr);
            check("rd_ar_len", ar_len, el);
            check("rd_ar_size", ar_size, 3'b010);
            check("rd_ar_burst", ar_burst, exp_burst());
            check("rd_no_rd_valid", rd_valid, 0);
            check("rd_no_r_ready", r_ready, 0);
            if (ar_ready) ar_done = 1;
            @(posedge a_clk); #1;
            cyc++;
        end
        check("rd_addr_phase_in_budget", cyc < 100, 1);
        ar_ready = 1'b0;
        cyc = 0;
        while (beats <= el && cyc < 300) begin
            r_valid  = (pct == 100) || ($urandom_range(1) == 1);
            rd_ready = toggle ? (cyc % 2 == 1) : ((pct == 100) || ($urandom_range(1) == 1));
            r_data   = $urandom;
            r_last   = (beats == el);
            r_resp   = (beats == err_beat) ? err_val :
                       ((err_beat >= 0 && beats > err_beat) ? 2'($urandom) : 2'b00);
            r_id     = (beats == bad_beat) ? bad_id : id;
            #1;
            check("rd_rd_valid", rd_valid, r_valid);
            check("rd_rd_data", rd_data, r_data);
            check("rd_rd_last", rd_last, r_last);
            check("rd_r_ready", r_ready, rd_ready);
            check("rd_ar_quiet", ar_valid, 0);
            check("rd_no_done", done_valid, 0);
            if (r_valid && rd_ready) begin
                if (r_id != id) mism = 1;
                if (first == 2'b00) first = r_resp;
                beats++;
            end
            @(posedge a_clk); #1;
            cyc++;
        end
        check("rd_data_phase_in_budget", cyc < 300, 1);
        r_valid = 1'b0; rd_ready = 1'b0; r_last = 1'b0;
        #1;
        check("rd_done_valid", done_valid, 1);
        check("rd_done_write", done_write, 0);
        check("rd_done_id", done_id, id);
        check("rd_done_resp", done_resp, mism ? 2'b10 : first);
        check("rd_done_cmd_ready", cmd_ready, 0);
        @(posedge a_clk); #1; #1;
        check("rd_done_pulse", done_valid, 0);
        check("rd_back_idle", cmd_ready, 1);
    endtask

    task automatic hold_test();
        int cyc;
        @(posedge a_clk); #1;
        h_cmd_valid = 1'b1;
        @(posedge a_clk); #1;
        h_cmd_valid = 1'b0;
        cyc = 0;
        while (!h_done_valid && cyc < 20) begin
            @(posedge a_clk); #1;
            cyc++;
        end
        check("hold_reaches_done", cyc < 20, 1);
        for (int i = 0; i < 10; i++) begin
            #1;
            check("hold_done_valid", h_done_valid, 1);
            check("hold_done_id", h_done_id, 4'h9);
            check("hold_done_resp", h_done_resp, 2'b01);
            check("hold_done_write", h_done_write, 1);
            check("hold_cmd_ready", h_cmd_ready, 0);
            check("hold_no_w_valid", h_w_valid, 0);
            @(posedge a_clk); #1;
        end
        h_done_ready = 1'b1;
        #1;
        check("hold_done_at_ready", h_done_valid, 1);
        @(posedge a_clk); #1;
        h_done_ready = 1'b0;
        #1;
        check("hold_released", h_done_valid, 0);
        check("hold_back_idle", h_cmd_ready, 1);
    endtask

    task automatic reset_mid_write();
        @(posedge a_clk); #1;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_id = 4'h6; cmd_addr = 32'h0000_2000; cmd_len = 4'd3;
        @(posedge a_clk); #1;
        cmd_valid = 1'b0;
        aw_ready = 1'b0; w_ready = 1'b1; wd_valid = 1'b1; wd_data = 32'h1111_0001;
        @(posedge a_clk); #1;
        wd_data = 32'h1111_0002;
        a_resetn = 1'b0;
        @(posedge a_clk); #1;
        a_resetn = 1'b1;
        rd_ready = 1'b1; r_valid = 1'b1; b_valid = 1'b1;
        #1;
        check("rst_aw_valid", aw_valid, 0);
        check("rst_w_valid", w_valid, 0);
        check("rst_ar_valid", ar_valid, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_b_ready", b_ready, 0);
        check("rst_r_ready", r_ready, 0);
        check("rst_done_resp", done_resp, 0);
        check("rst_cmd_ready", cmd_ready, 1);
        for (int i = 0; i < 4; i++) begin
            check("rst_no_done", done_valid, 0);
            @(posedge a_clk); #1;
        end
        idle_inputs();
    endtask

    initial begin
        logic [3:0] rid, rlen;
        int err_beat, bad_beat;
        idle_inputs();
        h_cmd_valid = 1'b0; h_done_ready = 1'b0;
        a_resetn = 1'b0;
        // Reset state, with inputs that would otherwise raise outputs.
        wd_valid = 1'b1; r_valid = 1'b1; rd_ready = 1'b1; b_valid = 1'b1;
        repeat (3) @(posedge a_clk);
        #1;
        check("reset_aw_valid", aw_valid, 0);
        check("reset_w_valid", w_valid, 0);
        check("reset_ar_valid", ar_valid, 0);
        check("reset_rd_valid", rd_valid, 0);
        check("reset_done_valid", done_valid, 0);
        check("reset_b_ready", b_ready, 0);
        check("reset_r_ready", r_ready, 0);
        check("reset_done_resp", done_resp, 0);
        check("reset_aw_addr", aw_addr, 0);
        check("reset_aw_id", aw_id, 0);
        check("reset_aw_len", aw_len, 0);
        a_resetn = 1'b1;
        #1;
        check("reset_cmd_ready", cmd_ready, 1);
        idle_inputs();

        hold_test();

        // Single write, fully ready slave.
        run_write(4'd3, 32'h0000_0100, 4'd0, 0, 100, 2'b00);
        // Four-beat write, AW accepted well after the data.
        run_write(4'd7, 32'h0000_1000, 4'd3, 9, 100, 2'b00);
        // Four-beat read with rd_ready toggling.
        run_read(4'd1, 32'h0000_3000, 4'd3, 100, 1'b1, -1, 2'b00, -1, 4'd0);
        // Error on beat 2 of 4.
        run_read(4'd4, 32'h0000_4000, 4'd3, 100, 1'b0, (INCR ? 1 : 0), 2'b11, -1, 4'd0);
        // Wrong r_id.
        run_read(4'd2, 32'h0000_5000, 4'd3, 100, 1'b0, -1, 2'b00, 0, 4'd5);

        reset_mid_write();
        run_write(4'd8, 32'h0000_6000, 4'd1, -1, 70, 2'b10);

        for (int n = 0; n < 40; n++) begin
            rid  = 4'($urandom);
            rlen = 4'($urandom);
            if ($urandom_range(1) == 1) begin
                run_write(rid, $urandom, rlen, -1, 60, 2'($urandom));
            end else begin
                err_beat = ($urandom_range(2) == 0) ? -1 : int'($urandom_range(eff_len(rlen)));
                bad_beat = ($urandom_range(3) == 0) ? int'($urandom_range(eff_len(rlen))) : -1;
                run_read(rid, $urandom, rlen, 70, ($urandom_range(1) == 1), err_beat,
                         2'($urandom), bad_beat, rid ^ 4'($urandom_range(15, 1)));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
